// File: rtl/cv32e40x_pkg.sv
// cv32e40x_pkg: shared types and constants for the iterative divider
//   div_opcode_e : decoded M-extension divide operation
//   div_state_e  : divider FSM states
//   DIV_CNT_W    : width of the per-bit iteration counter
package cv32e40x_pkg;

   typedef enum logic [1:0] {
      DIV_DIV  = 2'b00,
      DIV_DIVU = 2'b01,
      DIV_REM  = 2'b10,
      DIV_REMU = 2'b11
   } div_opcode_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

   localparam int DIV_CNT_W = 5;

endpackage

// File: rtl/cv32e40x_div_iter.sv
// cv32e40x_div_iter: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   valid_i    : operation request
//   operator_i : div_opcode_e
//   op_a_i     : dividend
//   op_b_i     : divisor
//   ready_o    : idle, can accept
//   kill_i     : flush, aborts any operation
//   valid_o    : result_o valid
//   ready_i    : consumer accepts result
//   result_o   : quotient or remainder
module cv32e40x_div_iter
   import cv32e40x_pkg::*;
#(
   parameter bit SHORTCUT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid_i,
   input  div_opcode_e operator_i,
   input  logic [31:0] op_a_i,
   input  logic [31:0] op_b_i,
   output logic        ready_o,
   input  logic        kill_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] result_o
);

   div_state_e           state_q;
   div_opcode_e          op_q;
   logic                 sign_a_q, sign_b_q;
   logic [31:0]          rem_q, quo_q, mag_b_q;
   logic [DIV_CNT_W-1:0] cnt_q;

   logic        signed_op, rem_op, sign_a, sign_b, div_zero, ovf, accept, shortcut;
   logic [31:0] mag_a, mag_b, special_res, rem_d, quo_d, fix_res;
   logic [32:0] trial;
   logic        q_neg, r_neg, rem_q_op;

   always_comb begin
      signed_op   = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
      rem_op      = (operator_i == DIV_REM) || (operator_i == DIV_REMU);
      sign_a      = signed_op & op_a_i[31];
      sign_b      = signed_op & op_b_i[31];
      // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned
      mag_a       = sign_a ? -op_a_i : op_a_i;
      mag_b       = sign_b ? -op_b_i : op_b_i;
      div_zero    = op_b_i == 32'h0;
      ovf         = signed_op && op_a_i == 32'h8000_0000 && op_b_i == 32'hFFFF_FFFF;
      special_res = div_zero ? (rem_op ? op_a_i : 32'hFFFF_FFFF) : (rem_op ? 32'h0 : 32'h8000_0000);
      shortcut    = SHORTCUT && (div_zero || ovf);
      accept      = valid_i & ready_o & !kill_i;
      // full-width partial remainder shift keeps large unsigned divisors exact
      trial       = {rem_q, quo_q[31]} - {1'b0, mag_b_q};
      rem_d       = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
      quo_d       = {quo_q[30:0], !trial[32]};
      q_neg       = (sign_a_q ^ sign_b_q) && mag_b_q != 32'h0;
      r_neg       = sign_a_q;
      rem_q_op    = (op_q == DIV_REM) || (op_q == DIV_REMU);
      fix_res     = rem_q_op ? (r_neg ? -rem_d : rem_d) : (q_neg ? -quo_d : quo_d);
   end

   assign ready_o = rst_n && state_q == IDLE;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         valid_o  <= 1'b0;
         result_o <= 32'h0;
         cnt_q    <= '0;
      end else if (kill_i) begin
         state_q <= IDLE;
         valid_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               op_q     <= operator_i;
               sign_a_q <= sign_a;
               sign_b_q <= sign_b;
               mag_b_q  <= mag_b;
               rem_q    <= 32'h0;
               quo_q    <= mag_a;
               cnt_q    <= DIV_CNT_W'(31);
               state_q  <= shortcut ? DONE : CALC;
               valid_o  <= shortcut;
               if (shortcut) result_o <= special_res;
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - DIV_CNT_W'(1);
               if (cnt_q == '0) begin
                  state_q  <= DONE;
                  valid_o  <= 1'b1;
                  result_o <= fix_res;
               end
            end
            DONE: if (ready_i) begin
               state_q <= IDLE;
               valid_o <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cv32e40x_div_iter.sv
// tb_cv32e40x_div_iter: randomized and directed bench for both SHORTCUT settings against an arithmetic model
module tb_cv32e40x_div_iter;
   import cv32e40x_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0, valid_i = 1'b0, kill_i = 1'b0, ready_i = 1'b1;
   div_opcode_e op_i = DIV_DIV;
   logic [31:0] a_i = '0, b_i = '0;
   logic        rdy1, v1, rdy0, v0;
   logic [31:0] r1, r0;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   cv32e40x_div_iter #(.SHORTCUT(1'b1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .operator_i(op_i), .op_a_i(a_i), .op_b_i(b_i),
      .ready_o(rdy1), .kill_i(kill_i), .valid_o(v1), .ready_i(ready_i), .result_o(r1));

   cv32e40x_div_iter #(.SHORTCUT(1'b0)) u_s0 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .operator_i(op_i), .op_a_i(a_i), .op_b_i(b_i),
      .ready_o(rdy0), .kill_i(kill_i), .valid_o(v0), .ready_i(ready_i), .result_o(r0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      bit sg = op == DIV_DIV || op == DIV_REM;
      bit rm = op == DIV_REM || op == DIV_REMU;
      if (b == 0) return rm ? a : 32'hFFFF_FFFF;
      if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'h0 : 32'h8000_0000;
      if (sg) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
      return rm ? a % b : a / b;
   endfunction

   function automatic bit is_special(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      return b == 0 || ((op == DIV_DIV || op == DIV_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // returns #1 after the accept edge, i.e. in cycle 1
   task automatic start(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      @(negedge clk);
      while (!(rdy0 && rdy1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", 32'({rdy0, rdy1}), 32'd3);
      valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(posedge clk);
      #1 valid_i = 1'b0;
   endtask

   task automatic run(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
      int l1 = 0, l0 = 0;
      logic [31:0] res1 = '0, res0 = '0, exp;
      exp = ref_div(op, a, b);
      start(op, a, b);
      for (int c = 1; c <= 40; c++) begin
         if (v1 && l1 == 0) begin l1 = c; res1 = r1; end
         if (v0 && l0 == 0) begin l0 = c; res0 = r0; end
         if (l1 != 0 && l0 != 0) break;
         @(posedge clk);
         #1;
      end
      chk($sformatf("res_sc1 %s %h %h", op.name(), a, b), res1, exp);
      chk($sformatf("res_sc0 %s %h %h", op.name(), a, b), res0, exp);
      chk("lat_sc1", 32'(l1), is_special(op, a, b) ? 32'd1 : 32'd33);
      chk("lat_sc0", 32'(l0), 32'd33);
   endtask

   initial begin
      logic [31:0] held;
      bit seen;
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(v0 | v1), 32'd0);
      chk("rst_result", r0 | r1, 32'h0);
      chk("rst_ready", 32'({rdy0, rdy1}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("ready_after_rst", 32'({rdy0, rdy1}), 32'd3);

      run(DIV_DIVU, 32'd100, 32'd7);
      @(posedge clk);
      #1 chk("ready_c34", 32'({rdy0, rdy1}), 32'd3);
      run(DIV_DIV, 32'hFFFF_FFF9, 32'd2);
      run(DIV_REM, 32'hFFFF_FFF9, 32'd2);
      run(DIV_REMU, 32'hFFFF_FFF9, 32'd2);
      run(DIV_DIV, 32'd5, 32'd0);
      run(DIV_DIV, 32'hFFFF_FFFB, 32'd0);
      run(DIV_REMU, 32'd5, 32'd0);
      run(DIV_REM, 32'hFFFF_FFFB, 32'd0);
      run(DIV_DIVU, 32'd5, 32'd0);
      run(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF);
      run(DIV_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
      run(DIV_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
      run(DIV_REMU, 32'hC000_0001, 32'h8000_0001);

      // kill in CALC cycle 10
      start(DIV_DIVU, 32'h1234_5678, 32'd3);
      repeat (9) begin @(posedge clk); #1; end
      kill_i = 1'b1;
      @(posedge clk);
      #1 kill_i = 1'b0;
      chk("kill_ready", 32'({rdy0, rdy1}), 32'd3);
      seen = 0;
      repeat (40) begin seen |= v0 | v1; @(posedge clk); #1; end
      chk("kill_no_valid", 32'(seen), 32'd0);
      run(DIV_DIVU, 32'd9, 32'd3);

      // kill beats accept in the same cycle
      @(negedge clk);
      valid_i = 1'b1; kill_i = 1'b1; op_i = DIV_DIVU; a_i = 32'd8; b_i = 32'd0;
      @(posedge clk);
      #1 valid_i = 1'b0; kill_i = 1'b0;
      chk("kill_vs_accept", 32'({rdy0, rdy1, v0, v1}), 32'b1100);

      // stall result for 5 cycles
      ready_i = 1'b0;
      start(DIV_DIV, 32'hFFFF_FF9C, 32'd7);
      n = 0;
      while (!(v0 && v1) && n < 60) begin @(posedge clk); #1; n++; end
      held = r0;
      chk("hold_first", held, ref_div(DIV_DIV, 32'hFFFF_FF9C, 32'd7));
      repeat (5) begin
         @(posedge clk);
         #1 chk("hold_stable", {r0[31:1], v0 & v1}, {held[31:1], 1'b1});
         chk("hold_result_sc1", r1, held);
      end
      chk("hold_no_ready", 32'({rdy0, rdy1}), 32'd0);
      ready_i = 1'b1;
      @(posedge clk);
      #1 chk("release_valid", 32'(v0 | v1), 32'd0);

      // reset mid-CALC
      start(DIV_DIVU, 32'd1000, 32'd9);
      repeat (5) begin @(posedge clk); #1; end
      run(DIV_DIVU, 32'd0, 32'd1);
      start(DIV_DIVU, 32'd1000, 32'd9);
      repeat (5) begin @(posedge clk); #1; end
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1 chk("rst_mid_result", r0 | r1, 32'h0);
      chk("rst_mid_valid", 32'({v0, v1, rdy0, rdy1}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst_mid_ready", 32'({rdy0, rdy1}), 32'd3);

      for (int i = 0; i < 60; i++) begin
         div_opcode_e op;
         logic [31:0] a, b;
         op = div_opcode_e'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: a = 32'h8000_0000;
            1: a = $urandom_range(0, 300);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: b = 32'h0;
            1: b = 32'hFFFF_FFFF;
            2: b = $urandom_range(1, 20);
            default: b = $urandom;
         endcase
         run(op, a, b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
